// File: rtl/calculator_if.sv
// calculator_if: operand inputs, seven-segment outputs and status LEDs of the calculator
interface calculator_if;
  logic [1:0] number;
  logic       sign;
  logic [1:0] operation;
  logic [6:0] display_input;
  logic [6:0] display_hundreds;
  logic [6:0] display_tens;
  logic [6:0] display_ones;
  logic       div_by_zero_led;
  logic       result_zero_led;
  logic       input_negative_led;
  logic       result_negative_led;
  modport master (
    output number, sign, operation,
    input  display_input, display_hundreds, display_tens, display_ones,
    input  div_by_zero_led, result_zero_led, input_negative_led, result_negative_led
  );
  modport slave (
    input  number, sign, operation,
    output display_input, display_hundreds, display_tens, display_ones,
    output div_by_zero_led, result_zero_led, input_negative_led, result_negative_led
  );
endinterface

// File: rtl/calculator.sv
// calculator: saturating signed accumulator (+,-,*,/) with decimal seven-segment readout
module calculator (
  input logic         clock,
  input logic         reset_n,
  calculator_if.slave bus
);
  logic signed [10:0] r_acc;
  logic               r_dbz;
  logic signed [12:0] w_mag, w_opnd, w_a, w_res;
  logic signed [10:0] w_sat;
  logic               w_dbz;
  logic [10:0]        w_abs;
  logic [3:0]         w_h, w_t, w_o;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      default: seg = 7'b0010000;
    endcase
  endfunction
  assign w_mag  = {11'd0, bus.number};
  assign w_opnd = bus.sign ? w_mag : -w_mag;
  assign w_a    = {{2{r_acc[10]}}, r_acc};
  assign w_dbz  = (bus.operation == 2'b11) && (bus.number == 2'd0);
  // divisor forced to 1 on divide-by-zero so the divider never sees 0
  always_comb begin
    w_res = bus.operation == 2'b00 ? w_a + w_opnd :
            bus.operation == 2'b01 ? w_a - w_opnd :
            bus.operation == 2'b10 ? w_a * w_opnd :
                                     w_a / (w_dbz ? 13'sd1 : w_opnd);
    w_sat = w_res > 13'sd999  ? 11'sd999 :
            w_res < -13'sd999 ? -11'sd999 : w_res[10:0];
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_acc <= '0;
      r_dbz <= 1'b0;
    end else begin
      r_acc <= w_dbz ? r_acc : w_sat;
      r_dbz <= w_dbz;
    end
  assign w_abs = r_acc[10] ? 11'(-r_acc) : 11'(r_acc);
  assign w_h   = 4'(w_abs / 11'd100);
  assign w_t   = 4'((w_abs / 11'd10) % 11'd10);
  assign w_o   = 4'(w_abs % 11'd10);
  assign bus.display_input       = seg({2'b00, bus.number});
  assign bus.display_hundreds    = seg(w_h);
  assign bus.display_tens        = seg(w_t);
  assign bus.display_ones        = seg(w_o);
  assign bus.div_by_zero_led     = r_dbz;
  assign bus.result_zero_led     = (r_acc == 11'sd0);
  assign bus.result_negative_led = r_acc[10];
  assign bus.input_negative_led  = ~bus.sign;
endmodule

// File: tb/tb_calculator.sv
// tb_calculator: directed-vector bench for the saturating accumulator calculator
module tb_calculator;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] segs [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  calculator_if bus ();
  calculator dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [22:0] expw(input int v);
    int a;
    a = v < 0 ? -v : v;
    return {v < 0, v == 0, segs[a / 100], segs[(a / 10) % 10], segs[a % 10]};
  endfunction
  function automatic logic [22:0] obsw();
    return {bus.result_negative_led, bus.result_zero_led,
            bus.display_hundreds, bus.display_tens, bus.display_ones};
  endfunction
  task automatic step(input string tag, input logic [1:0] n, input logic s,
                      input logic [1:0] op, input int v, input logic dbz);
    bus.number = n;
    bus.sign = s;
    bus.operation = op;
    #1;
    chk({tag, "_in"}, {24'd0, ~s, bus.input_negative_led, bus.display_input}, {24'd0, ~s, ~s, segs[n]});
    @(posedge clock);
    #1;
    chk({tag, "_acc"}, {9'd0, obsw()}, {9'd0, expw(v)});
    chk({tag, "_dbz"}, {31'd0, bus.div_by_zero_led}, {31'd0, dbz});
  endtask
  initial begin
    bus.number = 2'd0;
    bus.sign = 1'b0;
    bus.operation = 2'b00;
    #12;
    chk("rst_word", {9'd0, obsw()}, {9'd0, expw(0)});
    chk("rst_inneg", {31'd0, bus.input_negative_led}, 32'd1);
    chk("rst_disp_in", {25'd0, bus.display_input}, {25'd0, 7'b1000000});
    @(negedge clock);
    reset_n = 1'b1;
    step("add0", 2'd0, 1'b1, 2'b00, 0, 1'b0);
    step("add1", 2'd1, 1'b1, 2'b00, 1, 1'b0);
    step("add2", 2'd2, 1'b1, 2'b00, 3, 1'b0);
    step("subm1", 2'd1, 1'b0, 2'b01, 4, 1'b0);
    step("add3", 2'd3, 1'b1, 2'b00, 7, 1'b0);
    step("subm2", 2'd2, 1'b0, 2'b01, 9, 1'b0);
    chk("chain_ones", {25'd0, bus.display_ones}, {25'd0, 7'b0010000});
    step("div0", 2'd0, 1'b1, 2'b11, 9, 1'b1);
    step("div0_neg", 2'd0, 1'b0, 2'b11, 9, 1'b1);
    step("after_div0", 2'd1, 1'b1, 2'b00, 10, 1'b0);
    step("negzero_add", 2'd0, 1'b0, 2'b00, 10, 1'b0);
    step("to13", 2'd3, 1'b1, 2'b00, 13, 1'b0);
    step("to39", 2'd3, 1'b1, 2'b10, 39, 1'b0);
    step("to42", 2'd3, 1'b1, 2'b00, 42, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("async_rst", {9'd0, obsw()}, {9'd0, expw(0)});
    chk("async_rst_ones", {25'd0, bus.display_ones}, {25'd0, 7'b1000000});
    chk("async_rst_dbz", {31'd0, bus.div_by_zero_led}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step("neg_sub3", 2'd3, 1'b1, 2'b01, -3, 1'b0);
    chk("neg_ones3", {25'd0, bus.display_ones}, {25'd0, 7'b0110000});
    step("neg_mulm2", 2'd2, 1'b0, 2'b10, 6, 1'b0);
    chk("neg_ones6", {25'd0, bus.display_ones}, {25'd0, 7'b0000010});
    step("to3", 2'd3, 1'b0, 2'b00, 3, 1'b0);
    step("to1", 2'd2, 1'b0, 2'b00, 1, 1'b0);
    step("mul3_a", 2'd3, 1'b1, 2'b10, 3, 1'b0);
    step("mul3_b", 2'd3, 1'b1, 2'b10, 9, 1'b0);
    step("mul3_c", 2'd3, 1'b1, 2'b10, 27, 1'b0);
    step("mul3_d", 2'd3, 1'b1, 2'b10, 81, 1'b0);
    step("mul3_e", 2'd3, 1'b1, 2'b10, 243, 1'b0);
    step("mul3_f", 2'd3, 1'b1, 2'b10, 729, 1'b0);
    step("mul3_sat", 2'd3, 1'b1, 2'b10, 999, 1'b0);
    chk("sat_hund", {25'd0, bus.display_hundreds}, {25'd0, 7'b0010000});
    step("sat_add3", 2'd3, 1'b1, 2'b00, 999, 1'b0);
    step("sat_sub1", 2'd1, 1'b1, 2'b01, 998, 1'b0);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    step("tom3", 2'd3, 1'b1, 2'b01, -3, 1'b0);
    step("tom6", 2'd3, 1'b0, 2'b00, -6, 1'b0);
    step("tom7", 2'd1, 1'b0, 2'b00, -7, 1'b0);
    step("div_m7_2", 2'd2, 1'b1, 2'b11, -3, 1'b0);
    step("to6", 2'd2, 1'b0, 2'b10, 6, 1'b0);
    step("to7", 2'd1, 1'b1, 2'b00, 7, 1'b0);
    step("div_7_m2", 2'd2, 1'b0, 2'b11, -3, 1'b0);
    step("nmul_a", 2'd3, 1'b1, 2'b10, -9, 1'b0);
    step("nmul_b", 2'd3, 1'b1, 2'b10, -27, 1'b0);
    step("nmul_c", 2'd3, 1'b1, 2'b10, -81, 1'b0);
    step("nmul_d", 2'd3, 1'b1, 2'b10, -243, 1'b0);
    step("nmul_e", 2'd3, 1'b1, 2'b10, -729, 1'b0);
    step("nmul_sat", 2'd3, 1'b1, 2'b10, -999, 1'b0);
    step("nsat_sub", 2'd2, 1'b1, 2'b01, -999, 1'b0);
    step("nsat_add", 2'd1, 1'b1, 2'b00, -998, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
